// File: rtl/m5_mig_queue.sv
// Merges the hot-page and hot-cacheline migration address streams into one tagged request stream.
// Optional build macro M5_MIG_DEDUP_EN drops back-to-back duplicate addresses per source.
module m5_mig_queue #(
  parameter int ADDR_SIZE       = 28,
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_DEPTH_BITS = 4,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       page_mig_addr_en,
  input  logic [ADDR_SIZE-1:0]       page_mig_addr,
  output logic                       page_mig_addr_ready,
  input  logic                       cache_mig_addr_en,
  input  logic [ADDR_SIZE-1:0]       cache_mig_addr,
  output logic                       cache_mig_addr_ready,
  output logic                       mig_req_valid,
  output logic [ADDR_SIZE-1:0]       mig_req_addr,
  output logic                       mig_req_is_page,
  input  logic                       mig_req_ready,
  output logic [FIFO_DEPTH_BITS:0]   page_occ,
  output logic [FIFO_DEPTH_BITS:0]   cache_occ,
  output logic [CNT_WIDTH-1:0]       page_acc_cnt,
  output logic [CNT_WIDTH-1:0]       cache_acc_cnt,
  output logic [CNT_WIDTH-1:0]       drop_cnt
);

  // Handshake: a beat transfers on a rising edge where valid (en) and ready are both high;
  // the producer holds valid/data until then, and ready never depends on the same-cycle pop.
  localparam logic [FIFO_DEPTH_BITS:0]   OCC_ONE  = (FIFO_DEPTH_BITS+1)'(1);
  localparam logic [FIFO_DEPTH_BITS:0]   OCC_FULL = (FIFO_DEPTH_BITS+1)'(FIFO_DEPTH);
  localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE  = FIFO_DEPTH_BITS'(1);

  logic [ADDR_SIZE-1:0]       page_mem  [FIFO_DEPTH];
  logic [ADDR_SIZE-1:0]       cache_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] page_wr, page_rd, cache_wr, cache_rd;
  logic [FIFO_DEPTH_BITS:0]   page_occ_nxt, cache_occ_nxt;
  logic                       rr;

  logic page_acc, cache_acc, page_dup, cache_dup;
  logic page_push, cache_push, page_pop, cache_pop;
  logic page_ne, cache_ne, load, sel_page;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic [1:0] inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, cnt} + {{(CNT_WIDTH-1){1'b0}}, inc};
    return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  endfunction

`ifdef M5_MIG_DEDUP_EN
  logic [ADDR_SIZE-1:0] page_last, cache_last;
  logic                 page_last_vld, cache_last_vld;

  assign page_dup  = page_last_vld  && (page_last  == page_mig_addr);
  assign cache_dup = cache_last_vld && (cache_last == cache_mig_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      page_last      <= '0;
      cache_last     <= '0;
      page_last_vld  <= 1'b0;
      cache_last_vld <= 1'b0;
      drop_cnt       <= '0;
    end else begin
      if (page_push) begin
        page_last     <= page_mig_addr;
        page_last_vld <= 1'b1;
      end
      if (cache_push) begin
        cache_last     <= cache_mig_addr;
        cache_last_vld <= 1'b1;
      end
      if ((page_acc && page_dup) || (cache_acc && cache_dup))
        drop_cnt <= sat_inc(drop_cnt, {page_acc && page_dup && cache_acc && cache_dup,
                                       (page_acc && page_dup) ^ (cache_acc && cache_dup)});
    end
  end
`else
  assign page_dup  = 1'b0;
  assign cache_dup = 1'b0;
  assign drop_cnt  = '0;
`endif

  assign page_acc   = page_mig_addr_en  && page_mig_addr_ready;
  assign cache_acc  = cache_mig_addr_en && cache_mig_addr_ready;
  assign page_push  = page_acc  && !page_dup;
  assign cache_push = cache_acc && !cache_dup;

  assign page_ne   = (page_occ  != '0);
  assign cache_ne  = (cache_occ != '0);
  assign load      = !mig_req_valid || mig_req_ready;
  // With both sources pending rr decides; otherwise whichever one has data wins.
  assign sel_page  = page_ne && (!cache_ne || !rr);
  assign page_pop  = load && sel_page;
  assign cache_pop = load && cache_ne && !sel_page;

  always_comb begin
    page_occ_nxt = page_occ;
    if (page_push && !page_pop)      page_occ_nxt = page_occ + OCC_ONE;
    else if (!page_push && page_pop) page_occ_nxt = page_occ - OCC_ONE;
    cache_occ_nxt = cache_occ;
    if (cache_push && !cache_pop)      cache_occ_nxt = cache_occ + OCC_ONE;
    else if (!cache_push && cache_pop) cache_occ_nxt = cache_occ - OCC_ONE;
  end

  always_ff @(posedge clk) begin
    if (page_push)  page_mem[page_wr]   <= page_mig_addr;
    if (cache_push) cache_mem[cache_wr] <= cache_mig_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      page_wr              <= '0;
      page_rd              <= '0;
      cache_wr             <= '0;
      cache_rd             <= '0;
      page_occ             <= '0;
      cache_occ            <= '0;
      page_mig_addr_ready  <= 1'b0;
      cache_mig_addr_ready <= 1'b0;
      mig_req_valid        <= 1'b0;
      mig_req_addr         <= '0;
      mig_req_is_page      <= 1'b0;
      rr                   <= 1'b0;
      page_acc_cnt         <= '0;
      cache_acc_cnt        <= '0;
    end else begin
      if (page_push)  page_wr  <= page_wr + PTR_ONE;
      if (page_pop)   page_rd  <= page_rd + PTR_ONE;
      if (cache_push) cache_wr <= cache_wr + PTR_ONE;
      if (cache_pop)  cache_rd <= cache_rd + PTR_ONE;
      page_occ             <= page_occ_nxt;
      cache_occ            <= cache_occ_nxt;
      page_mig_addr_ready  <= (page_occ_nxt  != OCC_FULL);
      cache_mig_addr_ready <= (cache_occ_nxt != OCC_FULL);
      if (page_push)  page_acc_cnt  <= sat_inc(page_acc_cnt, 2'd1);
      if (cache_push) cache_acc_cnt <= sat_inc(cache_acc_cnt, 2'd1);
      // Serving page hands priority to cache next time, and vice versa.
      if (load) begin
        if (page_pop) begin
          mig_req_valid   <= 1'b1;
          mig_req_addr    <= page_mem[page_rd];
          mig_req_is_page <= 1'b1;
          rr              <= 1'b1;
        end else if (cache_pop) begin
          mig_req_valid   <= 1'b1;
          mig_req_addr    <= cache_mem[cache_rd];
          mig_req_is_page <= 1'b0;
          rr              <= 1'b0;
        end else begin
          mig_req_valid   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_m5_mig_queue.sv
// Directed bench for m5_mig_queue: per-source expected queues feed a negedge output monitor.
// Build with or without M5_MIG_DEDUP_EN; the dedup vector adapts its expectations.
module tb_m5_mig_queue;
  localparam int AW = 28;
  localparam int DB = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          page_mig_addr_en = 1'b0;
  logic [AW-1:0] page_mig_addr = '0;
  logic          page_mig_addr_ready;
  logic          cache_mig_addr_en = 1'b0;
  logic [AW-1:0] cache_mig_addr = '0;
  logic          cache_mig_addr_ready;
  logic          mig_req_valid;
  logic [AW-1:0] mig_req_addr;
  logic          mig_req_is_page;
  logic          mig_req_ready = 1'b1;
  logic [DB:0]   page_occ, cache_occ;
  logic [CW-1:0] page_acc_cnt, cache_acc_cnt, drop_cnt;

  m5_mig_queue dut (
    .clk(clk), .rst(rst),
    .page_mig_addr_en(page_mig_addr_en), .page_mig_addr(page_mig_addr),
    .page_mig_addr_ready(page_mig_addr_ready),
    .cache_mig_addr_en(cache_mig_addr_en), .cache_mig_addr(cache_mig_addr),
    .cache_mig_addr_ready(cache_mig_addr_ready),
    .mig_req_valid(mig_req_valid), .mig_req_addr(mig_req_addr),
    .mig_req_is_page(mig_req_is_page), .mig_req_ready(mig_req_ready),
    .page_occ(page_occ), .cache_occ(cache_occ),
    .page_acc_cnt(page_acc_cnt), .cache_acc_cnt(cache_acc_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  logic [AW-1:0] exp_page_q[$];
  logic [AW-1:0] exp_cache_q[$];
  logic [0:0]    exp_src_q[$];
  logic [CW-1:0] m_page_acc, m_cache_acc, m_drop;
  logic [AW-1:0] m_page_last, m_cache_last;
  logic          m_page_lv, m_cache_lv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_page_q.delete();
    exp_cache_q.delete();
    exp_src_q.delete();
    m_page_acc = '0; m_cache_acc = '0; m_drop = '0;
    m_page_last = '0; m_cache_last = '0; m_page_lv = 1'b0; m_cache_lv = 1'b0;
  endtask

  task automatic model_accept(input bit is_page, input logic [AW-1:0] a);
    bit dup;
`ifdef M5_MIG_DEDUP_EN
    dup = is_page ? (m_page_lv && m_page_last == a) : (m_cache_lv && m_cache_last == a);
`else
    dup = 1'b0;
`endif
    if (dup) m_drop++;
    else if (is_page) begin
      exp_page_q.push_back(a); m_page_acc++; m_page_last = a; m_page_lv = 1'b1;
    end else begin
      exp_cache_q.push_back(a); m_cache_acc++; m_cache_last = a; m_cache_lv = 1'b1;
    end
  endtask

  // One clock of stimulus; accepted beats are recorded in the model.
  task automatic drive(input bit pe, input logic [AW-1:0] pa, input bit ce, input logic [AW-1:0] ca);
    page_mig_addr_en = pe;  page_mig_addr = pa;
    cache_mig_addr_en = ce; cache_mig_addr = ca;
    if (pe && page_mig_addr_ready)  model_accept(1'b1, pa);
    if (ce && cache_mig_addr_ready) model_accept(1'b0, ca);
    step();
    page_mig_addr_en = 1'b0;
    cache_mig_addr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    model_clear();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_page_q.size() != 0 || exp_cache_q.size() != 0 || mig_req_valid) && k < 200) begin
      step();
      k++;
    end
    check({name, "_drained"}, 64'(exp_page_q.size() + exp_cache_q.size()), 64'd0);
    check({name, "_page_acc"}, 64'(page_acc_cnt), 64'(m_page_acc));
    check({name, "_cache_acc"}, 64'(cache_acc_cnt), 64'(m_cache_acc));
    check({name, "_drop"}, 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, 64'(mig_req_valid), 64'd0);
    check({name, "_addr"}, 64'(mig_req_addr), 64'd0);
    check({name, "_is_page"}, 64'(mig_req_is_page), 64'd0);
    check({name, "_readies"}, 64'({page_mig_addr_ready, cache_mig_addr_ready}), 64'd0);
    check({name, "_occ"}, 64'({page_occ, cache_occ}), 64'd0);
    check({name, "_cnts"}, 64'(page_acc_cnt | cache_acc_cnt | drop_cnt), 64'd0);
  endtask

  // Output monitor: compares each consumed request and checks stalls hold their payload.
  logic          hold_pend = 1'b0;
  logic [AW-1:0] hold_addr;
  logic          hold_pg;
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        n_vec++;
        if (!(mig_req_valid && mig_req_addr == hold_addr && mig_req_is_page == hold_pg)) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%0b a=0x%0h p=%0b expected v=1 a=0x%0h p=%0b",
                   mig_req_valid, mig_req_addr, mig_req_is_page, hold_addr, hold_pg);
        end
      end
      hold_pend = mig_req_valid && !mig_req_ready;
      hold_addr = mig_req_addr;
      hold_pg   = mig_req_is_page;
      if (mig_req_valid && mig_req_ready) begin
        logic [AW-1:0] e;
        n_vec++;
        if (exp_src_q.size() != 0) begin
          logic [0:0] s;
          s = exp_src_q.pop_front();
          if (mig_req_is_page !== s) begin
            n_fail++;
            $display("FAIL rr_order: got is_page=%0b expected %0b", mig_req_is_page, s);
          end
        end
        if (mig_req_is_page ? exp_page_q.size() == 0 : exp_cache_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_unexpected: got a=0x%0h p=%0b expected none", mig_req_addr, mig_req_is_page);
        end else begin
          e = mig_req_is_page ? exp_page_q.pop_front() : exp_cache_q.pop_front();
          if (mig_req_addr !== e) begin
            n_fail++;
            $display("FAIL out_addr: got 0x%0h p=%0b expected 0x%0h", mig_req_addr, mig_req_is_page, e);
          end
        end
      end
    end
  end

  initial begin
    model_clear();
    // Reset values, during reset and on the first cycle after it.
    rst = 1'b1;
    step();
    step();
    check_all_zero("rst_hold");
    rst = 1'b0;
    check_all_zero("rst_first");
    step();
    check("rst_ready_up", 64'({page_mig_addr_ready, cache_mig_addr_ready}), 64'b11);

    // Single page push: visible after the following edge.
    drive(1'b1, 28'h0000123, 1'b0, '0);
    check("single_occ", 64'(page_occ), 64'd1);
    check("single_not_yet", 64'(mig_req_valid), 64'd0);
    step();
    check("single_out", 64'({mig_req_valid, mig_req_is_page, mig_req_addr}), {34'd0, 2'b11, 28'h0000123});
    check("single_acc", 64'(page_acc_cnt), 64'd1);
    drain("single");

    // Both sources every cycle from reset: strict page/cache alternation.
    do_reset();
    step();
    for (int i = 0; i < 8; i++) begin
      exp_src_q.push_back(1'b1);
      exp_src_q.push_back(1'b0);
      drive(1'b1, 28'h0000100 + 28'(i), 1'b1, 28'h0000200 + 28'(i));
    end
    drain("alt");
    check("alt_src_left", 64'(exp_src_q.size()), 64'd0);

    // Fill the page FIFO with the consumer stalled.
    mig_req_ready = 1'b0;
    for (int i = 0; i < 17; i++) drive(1'b1, 28'h0000300 + 28'(i), 1'b0, '0);
    check("full_occ", 64'(page_occ), 64'd16);
    check("full_ready", 64'(page_mig_addr_ready), 64'd0);
    check("full_out", 64'({mig_req_valid, mig_req_addr}), {35'd0, 1'b1, 28'h0000300});
    drive(1'b1, 28'h00003FF, 1'b0, '0);
    check("full_18th_occ", 64'(page_occ), 64'd16);
    check("full_18th_acc", 64'(page_acc_cnt), 64'(m_page_acc));

    // Release the consumer with the producer still asserting.
    mig_req_ready = 1'b1;
    drive(1'b1, 28'h00003FF, 1'b0, '0);
    check("refill_ready", 64'(page_mig_addr_ready), 64'd1);
    for (int j = 0; j < 4; j++) drive(1'b1, 28'h0000400 + 28'(j), 1'b0, '0);
    drain("refill");

    // Reset with 5 buffered entries and a pending request.
    mig_req_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b1, 28'h0000600 + 28'(i), 1'b0, '0);
    check("pre_rst_state", 64'({mig_req_valid, page_occ}), 64'({1'b1, 5'd5}));
    rst = 1'b1;
    step();
    check_all_zero("midrst");
    model_clear();
    rst = 1'b0;
    mig_req_ready = 1'b1;
    step();
    drive(1'b1, 28'h0000555, 1'b0, '0);
    step();
    check("post_rst_out", 64'({mig_req_valid, mig_req_addr}), {35'd0, 1'b1, 28'h0000555});
    drain("post_rst");

    // Cache sequence A, A, B, A.
    do_reset();
    step();
    drive(1'b0, '0, 1'b1, 28'h000000A);
    drive(1'b0, '0, 1'b1, 28'h000000A);
    drive(1'b0, '0, 1'b1, 28'h000000B);
    drive(1'b0, '0, 1'b1, 28'h000000A);
    drain("dedup");
`ifdef M5_MIG_DEDUP_EN
    check("dedup_drop_hand", 64'(drop_cnt), 64'd1);
    check("dedup_acc_hand", 64'(cache_acc_cnt), 64'd3);
`else
    check("dedup_drop_hand", 64'(drop_cnt), 64'd0);
    check("dedup_acc_hand", 64'(cache_acc_cnt), 64'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1, "timeout");
  end
endmodule
